cs_series_proc: RTL and testbench

- Parametrised streaming successor of the CS series processor. It keeps a sliding window of the last WIN input samples and emits one result per accepted sample once the window is full.
- Result: Y = (sum + WIN*Xappr) >> SHIFT, where Xappr is a window element selected against the window average.
- New over the previous generation: generic widths and window depth, a valid handshake, a selectable approximation mode, synchronous flush and output saturation.
- Sits between the sample source and the result sink in the CS datapath.

---
 rtl/cs_pkg.sv | 33 +++
 rtl/cs_series_proc_if.sv | 23 ++
 rtl/cs_appr_select.sv | 39 +++
 rtl/cs_series_proc.sv | 109 ++++++++++
 tb/tb_cs_series_proc.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/cs_pkg.sv
// Shared constants and helpers for the CS series processor.
package cs_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_WIN    = 9;

  // Running-sum width: holds WIN samples of DATA_W bits without overflow.
  function automatic int unsigned calc_sum_w(int unsigned data_w, int unsigned win);
    return data_w + $clog2(win + 1);
  endfunction

  // Product width: wide enough for sample*WIN and sum + WIN*sample.
  function automatic int unsigned calc_prod_w(int unsigned data_w, int unsigned win);
    return calc_sum_w(data_w, win) + $clog2(win + 1);
  endfunction

  localparam int unsigned SUM_W  = calc_sum_w(DEF_DATA_W, DEF_WIN);
  localparam int unsigned PROD_W = calc_prod_w(DEF_DATA_W, DEF_WIN);

  localparam logic MODE_LE = 1'b0;  // largest entry at or below the average
  localparam logic MODE_GE = 1'b1;  // smallest entry at or above the average

  // Shift right, then clamp to the largest value representable in out_w bits (out_w < 64).
  function automatic logic [63:0] sat_shift(logic [63:0] val, int unsigned shift,
                                            int unsigned out_w);
    logic [63:0] shifted;
    logic [63:0] max_val;
    shifted = val >> shift;
    max_val = (64'd1 << out_w) - 64'd1;
    return (shifted > max_val) ? max_val : shifted;
  endfunction

endpackage

// File: rtl/cs_series_proc_if.sv
// Sample/result stream between the source, the processor and the sink.
interface cs_series_proc_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 10
);
  logic              in_valid;
  logic [DATA_W-1:0] X;
  logic              mode;
  logic              clear;
  logic              out_valid;
  logic [OUT_W-1:0]  Y;
  logic              full;

  modport master (
    output in_valid, X, mode, clear,
    input  out_valid, Y, full
  );

  modport slave (
    input  in_valid, X, mode, clear,
    output out_valid, Y, full
  );
endinterface

// File: rtl/cs_appr_select.sv
// Picks the window entry closest to the average from below (mode 0) or above (mode 1),
// comparing Xi*WIN against the sum so no divider is needed.
module cs_appr_select
  import cs_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN    = 9
) (
  input  logic [WIN*DATA_W-1:0]                   win_flat,
  input  logic [calc_sum_w(DATA_W, WIN)-1:0]      sum,
  input  logic                                    mode,
  output logic [DATA_W-1:0]                       xappr
);

  localparam int unsigned ProdW = calc_prod_w(DATA_W, WIN);

  logic [DATA_W-1:0] xi;
  logic [ProdW-1:0]  prod;
  logic [ProdW-1:0]  sum_ext;

  // Linear scan; the window min (mode 0) or max (mode 1) always qualifies, so the
  // starting value is always replaced or already correct.
  always_comb begin
    xi      = '0;
    prod    = '0;
    sum_ext = ProdW'(sum);
    xappr   = (mode == MODE_LE) ? '0 : '1;
    for (int i = 0; i < int'(WIN); i++) begin
      xi   = win_flat[i*DATA_W +: DATA_W];
      prod = ProdW'(xi) * ProdW'(WIN);
      if (mode == MODE_LE) begin
        if (prod <= sum_ext && xi > xappr) xappr = xi;
      end else begin
        if (prod >= sum_ext && xi < xappr) xappr = xi;
      end
    end
  end

endmodule

// File: rtl/cs_series_proc.sv
// Sliding-window series processor: one saturated result per accepted sample once full.
module cs_series_proc
  import cs_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN    = 9,
  parameter int unsigned SHIFT  = 3,
  parameter int unsigned OUT_W  = 10
) (
  input logic             clk,
  input logic             reset,
  cs_series_proc_if.slave bus
);

  localparam int unsigned SumW = calc_sum_w(DATA_W, WIN);
  localparam int unsigned CntW = $clog2(WIN + 1);

  logic [DATA_W-1:0]     win_q [WIN];
  logic [DATA_W-1:0]     win_d [WIN];
  logic [SumW-1:0]       sum_q, sum_d;
  logic [CntW-1:0]       fill_q, fill_d;
  logic                  mode_q, mode_d;
  logic                  pend_q, pend_d;
  logic                  valid_q, valid_d;
  logic [OUT_W-1:0]      y_q, y_d;
  logic [WIN*DATA_W-1:0] win_flat;
  logic [DATA_W-1:0]     xappr;
  logic [DATA_W-1:0]     oldest;
  logic                  accept;
  logic                  full;
  logic [63:0]           total;
  logic [63:0]           y_full;

  assign full = (fill_q == CntW'(WIN));

  // Flatten the window (entry 0 = newest) for the selector.
  always_comb begin
    win_flat = '0;
    for (int i = 0; i < int'(WIN); i++) win_flat[i*DATA_W +: DATA_W] = win_q[i];
  end

  cs_appr_select #(
    .DATA_W (DATA_W),
    .WIN    (WIN)
  ) u_appr_select (
    .win_flat (win_flat),
    .sum      (sum_q),
    .mode     (mode_q),
    .xappr    (xappr)
  );

  // Window, running sum and fill update; clear wins over an incoming sample.
  always_comb begin
    accept = bus.in_valid & ~bus.clear;
    oldest = full ? win_q[WIN-1] : '0;
    for (int i = 0; i < int'(WIN); i++) win_d[i] = win_q[i];
    sum_d  = sum_q;
    fill_d = fill_q;
    mode_d = mode_q;
    pend_d = 1'b0;
    if (bus.clear) begin
      for (int i = 0; i < int'(WIN); i++) win_d[i] = '0;
      sum_d  = '0;
      fill_d = '0;
      mode_d = 1'b0;
    end else if (accept) begin
      win_d[0] = bus.X;
      for (int i = 1; i < int'(WIN); i++) win_d[i] = win_q[i-1];
      sum_d  = sum_q + SumW'(bus.X) - SumW'(oldest);
      fill_d = full ? fill_q : fill_q + CntW'(1);
      mode_d = bus.mode;
      pend_d = (fill_d == CntW'(WIN));
    end
  end

  // Result computed from the registered window one edge after a full accept.
  always_comb begin
    total   = 64'(sum_q) + 64'(WIN) * 64'(xappr);
    y_full  = sat_shift(total, SHIFT, OUT_W);
    valid_d = pend_q;
    y_d     = pend_q ? y_full[OUT_W-1:0] : y_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(WIN); i++) win_q[i] <= '0;
      sum_q   <= '0;
      fill_q  <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= '0;
    end else begin
      for (int i = 0; i < int'(WIN); i++) win_q[i] <= win_d[i];
      sum_q   <= sum_d;
      fill_q  <= fill_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      y_q     <= y_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.Y         = y_q;
  assign bus.full      = full;

endmodule

// File: tb/tb_cs_series_proc.sv
// Randomised and directed bench for cs_series_proc against a queue-based reference model.
module tb_cs_series_proc;

  localparam int WIN   = 9;
  localparam int SHIFT = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cs_series_proc_if #(.DATA_W(8), .OUT_W(10)) bus ();
  cs_series_proc_if #(.DATA_W(8), .OUT_W(9))  bus9 ();

  cs_series_proc #(.DATA_W(8), .WIN(WIN), .SHIFT(SHIFT), .OUT_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cs_series_proc #(.DATA_W(8), .WIN(WIN), .SHIFT(SHIFT), .OUT_W(9)) dut9 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus9)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Reference model: window as a queue (front = newest) plus the result in flight.
  int q[$];
  bit pend = 1'b0;
  int pend_y10, pend_y9;
  int last_y10 = 0;
  int last_y9  = 0;
  int obs_valid, obs_y, obs_y9;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_eval(input bit m, output int y10, output int y9);
    int s;
    int xa;
    int raw;
    s = 0;
    foreach (q[i]) s += q[i];
    xa = m ? 1000 : -1;
    foreach (q[i]) begin
      if (!m && q[i] * WIN <= s && q[i] > xa) xa = q[i];
      if (m && q[i] * WIN >= s && q[i] < xa) xa = q[i];
    end
    raw = (s + WIN * xa) >>> SHIFT;
    y10 = (raw > 1023) ? 1023 : raw;
    y9  = (raw > 511) ? 511 : raw;
  endfunction

  task automatic drive(input bit v, input int x, input bit m, input bit c);
    bus.in_valid  = v;  bus.X  = 8'(x);  bus.mode  = m;  bus.clear  = c;
    bus9.in_valid = v;  bus9.X = 8'(x);  bus9.mode = m;  bus9.clear = c;
  endtask

  // One clock: drive on the falling edge, check just after the rising edge, advance model.
  task automatic step(input bit v, input int x, input bit m, input bit c);
    @(negedge clk);
    drive(v, x, m, c);
    @(posedge clk);
    #1;
    obs_valid = int'(bus.out_valid);
    obs_y     = int'(bus.Y);
    obs_y9    = int'(bus9.Y);
    check_eq("out_valid", 32'(bus.out_valid), 32'(pend));
    check_eq("out_valid_w9", 32'(bus9.out_valid), 32'(pend));
    if (pend) begin
      last_y10 = pend_y10;
      last_y9  = pend_y9;
    end
    check_eq("y", 32'(bus.Y), 32'(last_y10));
    check_eq("y_w9", 32'(bus9.Y), 32'(last_y9));
    if (c) begin
      q.delete();
      pend = 1'b0;
    end else if (v) begin
      q.push_front(x);
      if (q.size() > WIN) void'(q.pop_back());
      pend = (q.size() == WIN);
      if (pend) model_eval(m, pend_y10, pend_y9);
    end else begin
      pend = 1'b0;
    end
    check_eq("full", 32'(bus.full), 32'(q.size() == WIN));
  endtask

  task automatic async_reset();
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_y", 32'(bus.Y), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_y_w9", 32'(bus9.Y), 32'd0);
    q.delete();
    pend     = 1'b0;
    last_y10 = 0;
    last_y9  = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    #3;
    check_eq("init_y", 32'(bus.Y), 32'd0);
    check_eq("init_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("init_full", 32'(bus.full), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Fill 1..9 in mode 0, then a gap: a single result of 11.
    for (int i = 1; i <= 9; i++) step(1'b1, i, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check_eq("fill_1to9_valid", 32'(obs_valid), 32'd1);
    check_eq("fill_1to9_y", 32'(obs_y), 32'd11);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0);

    // Window of eight zeros and a nine, in each mode.
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check_eq("zeros9_mode0_y", 32'(obs_y), 32'd1);
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b1, 1'b0);
    step(1'b1, 9, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check_eq("zeros9_mode1_y", 32'(obs_y), 32'd11);

    // All-maximum samples: largest result, saturated in the narrow instance.
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 255, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check_eq("max_y", 32'(obs_y), 32'd573);
    check_eq("max_y_w9", 32'(obs_y9), 32'd511);

    // Sliding window 10..100 back to back.
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) step(1'b1, 10 * i, 1'b0, 1'b0);
    check_eq("slide_first_y", 32'(obs_y), 32'd112);
    step(1'b0, 0, 1'b0, 1'b0);
    check_eq("slide_second_valid", 32'(obs_valid), 32'd1);
    step(1'b0, 0, 1'b0, 1'b0);

    // Clear after five samples, then refill with 1..9.
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 200, 1'b0, 1'b0);
    step(1'b1, 77, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) step(1'b1, i, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check_eq("post_clear_y", 32'(obs_y), 32'd11);

    // Asynchronous reset mid-stream, then a full refill.
    for (int i = 0; i < 6; i++) step(1'b1, 30 + i, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 40 + 5 * i, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);

    // Random traffic with gaps, clears and mode changes.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 24) == 0);
    end
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
